multdiv_iter: RTL
=================

// Module: multdiv_iter
// PURPOSE
//   Iterative signed 32-bit multiply/divide unit. Consumes the mult/div request
//   pulses and A/B operands launched by the M/D pipeline latch. Returns a result,
//   an exception flag and a one-cycle ready pulse, which clears the latch stall.
//   One multi-cycle operation is in flight at a time. Results are held until the
//   next start.
// PARAMETERS
//   WIDTH   32   operand/result width; iteration count equals WIDTH
// PORTS
//   clk             in   1      single clock, rising edge
//   reset           in   1      synchronous, active-high
//   ctrl_MULT       in   1      start-multiply pulse, sampled every edge
//   ctrl_DIV        in   1      start-divide pulse, sampled every edge
//   data_operandA   in   WIDTH  multiplicand / dividend (two's complement)
//   data_operandB   in   WIDTH  multiplier / divisor (two's complement)
//   data_result     out  WIDTH  low WIDTH bits of product, or quotient
//   data_exception  out  1      overflow / divide-by-zero flag, valid with rdy
//   data_resultRDY  out  1      one-cycle pulse: result and exception valid
//   busy            out  1      high while an operation is iterating
// BEHAVIOUR
//   - Reset (sync, active-high) wins over all inputs. It forces state=IDLE,
//     counter=0, data_result=0, data_exception=0, data_resultRDY=0 and busy=0.
//     Reset applied mid-operation aborts the operation; no rdy pulse follows.
//   - States: IDLE -> MULT | DIV -> DONE -> IDLE.
//   - Start: ctrl_MULT or ctrl_DIV high at edge k. Operands are captured at edge k
//     and need not be held afterwards. The counter is cleared and busy=1 from
//     edge k on.
//   - If ctrl_MULT and ctrl_DIV are both high, MULT wins and DIV is ignored.
//   - A start in any state (MULT, DIV, DONE) aborts the current op and restarts.
//     No rdy pulse is emitted for the aborted op.
//   - Latency: one iteration per cycle, WIDTH iterations. State enters DONE at
//     edge k+WIDTH. data_resultRDY=1 for exactly the cycle between edges k+WIDTH
//     and k+WIDTH+1; busy=0 in that cycle. The next edge returns to IDLE.
//   - data_result and data_exception update only at entry to DONE. Otherwise
//     they hold their values, including through IDLE, until the next DONE or reset.
//   - MULT: radix-2 shift-add on magnitudes, sign applied at the end. The full
//     2*WIDTH product is formed internally. data_result = product[WIDTH-1:0].
//     data_exception=1 iff product[2W-1:W] is not the sign extension of
//     product[W-1].
//   - DIV: restoring division on magnitudes. The quotient is truncated toward
//     zero, and its sign is signA XOR signB. The remainder is discarded.
//   - DIV, B==0: the full latency still applies; data_result=0, data_exception=1.
//   - DIV, A==-2^(W-1) and B==-1: data_result=32'h80000000, data_exception=1.
//   - Magnitude of -2^(W-1) is handled with a W+1-bit internal datapath. There
//     is no wrap inside the iteration.
//   - Operand changes after edge k have no effect on the op in flight.
// TESTING
//   1. MULT A=6, B=-7 -> rdy exactly 32 cycles after start; result=32'hFFFFFFD6
//      (-42), exc=0.
//   2. MULT A=32'h00010000, B=32'h00010000 -> result=0, exc=1 (overflow).
//   3. DIV A=-100, B=7 -> result=-14 (32'hFFFFFFF2), exc=0. DIV A=5, B=0 ->
//      result=0, exc=1, same latency.
//   4. DIV A=32'h80000000, B=-1 -> result=32'h80000000, exc=1. MULT
//      A=32'h80000000, B=1 -> result=32'h80000000, exc=0.
//   5. Start MULT 3*4; at cycle 10 start DIV 20/5 -> single rdy at cycle 10+32,
//      result=4. No rdy at cycle 32.
//   6. Start DIV, assert reset at cycle 15 -> busy=0, result=0, no rdy pulse.
//      Both ctrl pulses high with A=9, B=3 -> result=27 (MULT priority).

Source files
------------

// File: rtl/multdiv_iter.sv
// multdiv_iter: iterative signed multiply (shift-add) / divide (restoring), one bit per cycle.
// Magnitudes carry an extra bit so that -2^(WIDTH-1) never wraps inside the iteration.
module multdiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0, MULT = 2'd1, DIV = 2'd2, DONE = 2'd3;
    localparam int CW = $clog2(WIDTH) + 1;

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     mag_a, mag_b, dvsr, rem, rem_n, shifted;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] mcand, prod, prod_n, prod_s;
    logic [WIDTH-1:0]   mplier, quo, quo_n, res_n;
    logic               neg, div_zero, div_exc, exc_n, start, last;

    assign start          = ctrl_MULT | ctrl_DIV;
    assign last           = count == CW'(WIDTH - 1);
    assign data_resultRDY = state == DONE;
    assign busy           = (state == MULT) | (state == DIV);
    assign mag_a = data_operandA[WIDTH-1] ? ~{1'b1, data_operandA} + 1'b1 : {1'b0, data_operandA};
    assign mag_b = data_operandB[WIDTH-1] ? ~{1'b1, data_operandB} + 1'b1 : {1'b0, data_operandB};

    always_comb begin
        prod_n  = mplier[0] ? prod + mcand : prod;
        shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
        diff    = {1'b0, shifted} - {1'b0, dvsr};
        rem_n   = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
        quo_n   = {quo[WIDTH-2:0], ~diff[WIDTH+1]};
        prod_s  = neg ? ~prod_n + 1'b1 : prod_n;
        res_n   = (state == MULT) ? prod_s[WIDTH-1:0] :
                  div_zero ? '0 : neg ? ~quo_n + 1'b1 : quo_n;
        exc_n   = (state == MULT) ? (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}}) : div_exc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            state    <= ctrl_MULT ? MULT : DIV;
            count    <= '0;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            mcand    <= {{(WIDTH-1){1'b0}}, mag_a};
            mplier   <= mag_b[WIDTH-1:0];
            prod     <= '0;
            rem      <= '0;
            quo      <= mag_a[WIDTH-1:0];
            dvsr     <= mag_b;
            div_zero <= data_operandB == '0;
            // -2^(W-1) / -1 is the only quotient that does not fit
            div_exc  <= (data_operandB == '0) |
                        ((data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) & (&data_operandB));
        end else if (busy) begin
            count  <= count + 1'b1;
            prod   <= prod_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_n;
            quo    <= quo_n;
            if (last) begin
                state          <= DONE;
                data_result    <= res_n;
                data_exception <= exc_n;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
endmodule
